lu_arbiter: RTL



---
 rtl/lu_arb_pkg.sv | 18 +
 rtl/lu_core.sv | 22 ++
 rtl/lu_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/lu_arb_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter.
// Op-code encodings, FSM state type and the default datapath width.
package lu_arb_pkg;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic [1:0] OP_XNOR = 2'b00;
   localparam logic [1:0] OP_XOR  = 2'b01;
   localparam logic [1:0] OP_NOR  = 2'b10;
   localparam logic [1:0] OP_OR   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/lu_core.sv
// Combinational logic unit: bitwise XNOR / XOR / NOR / OR selected by op.
module lu_core
   import lu_arb_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      case (op)
         OP_XNOR: y = ~(a ^ b);
         OP_XOR:  y = a ^ b;
         OP_NOR:  y = ~(a | b);
         default: y = a | b;
      endcase
   end

endmodule

// File: rtl/lu_arbiter.sv
// Round-robin arbiter/sequencer sharing one lu_core between two requesters.
// Optional grant counters are enabled by defining LU_ARB_STATS_EN.
module lu_arbiter
   import lu_arb_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_id
`ifdef LU_ARB_STATS_EN
   ,
   output logic [7:0]       gnt0_cnt,
   output logic [7:0]       gnt1_cnt
`endif
);

   state_t           r_state;
   state_t           w_next_state;
   logic             r_last_grant;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_op;
   logic             r_id;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_id;

   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_accept;
   logic [WIDTH-1:0] w_lu_y;

   // r_last_grant == 1 means requester 1 was served last, so requester 0 wins a tie.
   assign w_gnt0   = req0_valid && (!req1_valid || r_last_grant);
   assign w_gnt1   = req1_valid && (!req0_valid || !r_last_grant);
   assign w_accept = (r_state == IDLE) && (w_gnt0 || w_gnt1);

   lu_core #(.WIDTH(WIDTH)) u_lu_core (
      .a  (r_a),
      .b  (r_b),
      .op (r_op),
      .y  (w_lu_y)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: default assignment first so no path through the case leaves the signal unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_gnt0 || w_gnt1) w_next_state = EXEC;
         EXEC:    w_next_state = RESP;
         RESP:    if (rsp_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Readies are masked by reset so they read 0 while reset is held.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp_valid  = 1'b0;
      case (r_state)
         IDLE: begin
            req0_ready = w_gnt0 && !reset;
            req1_ready = w_gnt1 && !reset;
         end
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_grant <= 1'b1;
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= OP_XNOR;
         r_id         <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_id     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a          <= w_gnt1 ? req1_a  : req0_a;
            r_b          <= w_gnt1 ? req1_b  : req0_b;
            r_op         <= w_gnt1 ? req1_op : req0_op;
            r_id         <= w_gnt1;
            r_last_grant <= w_gnt1;
         end
         if (r_state == EXEC) begin
            r_rsp_data <= w_lu_y;
            r_rsp_id   <= r_id;
         end
      end
   end

   assign rsp_data = r_rsp_data;
   assign rsp_id   = r_rsp_id;

`ifdef LU_ARB_STATS_EN
   logic [7:0] r_gnt0_cnt;
   logic [7:0] r_gnt1_cnt;

   // Saturating at 8'hFF; only reset clears them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_gnt0_cnt <= 8'd0;
         r_gnt1_cnt <= 8'd0;
      end else if (w_accept) begin
         if (w_gnt0 && (r_gnt0_cnt != 8'hFF)) r_gnt0_cnt <= r_gnt0_cnt + 8'd1;
         if (w_gnt1 && (r_gnt1_cnt != 8'hFF)) r_gnt1_cnt <= r_gnt1_cnt + 8'd1;
      end
   end

   assign gnt0_cnt = r_gnt0_cnt;
   assign gnt1_cnt = r_gnt1_cnt;
`endif

endmodule
